// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives a combinational 4-bit ALU from a 4x4 register file, one instruction per 3 cycles (LDI per 2).
module alu_op_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [11:0] instr,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [3:0]  alu_sel,
    input  logic [3:0]  alu_c,
    output logic        wb_valid,
    output logic [1:0]  wb_addr,
    output logic [3:0]  wb_data,
    input  logic [1:0]  rd_addr,
    output logic [3:0]  rd_data,
    output logic [7:0]  retired
);
    typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;
    state_t state, state_nx;
    logic [3:0][3:0] regs;
    logic [1:0] rd_q;
    logic accept, ldi;
    assign instr_ready = (state == IDLE) & !rst;
    assign accept = instr_valid & instr_ready;
    assign ldi = instr[11:8] == 4'hf;
    assign rd_data = regs[rd_addr];
    always_comb begin
        state_nx = state;
        state_nx = state == EXEC ? WRITE : state == WRITE ? IDLE : accept ? (ldi ? WRITE : EXEC) : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            regs     <= '0;
            rd_q     <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            retired  <= '0;
        end else begin
            state    <= state_nx;
            wb_valid <= 1'b0;
            if (accept && ldi) begin
                regs[instr[7:6]] <= instr[3:0];
                wb_addr          <= instr[7:6];
                wb_data          <= instr[3:0];
                wb_valid         <= 1'b1;
            end else if (accept) begin
                alu_a   <= regs[instr[5:4]];
                alu_b   <= regs[instr[3:2]];
                alu_sel <= instr[11:8];
                rd_q    <= instr[7:6];
            end
            if (state == EXEC) begin
                regs[rd_q] <= alu_c;
                wb_addr    <= rd_q;
                wb_data    <= alu_c;
                wb_valid   <= 1'b1;
            end
            if (state == WRITE)
                retired <= retired + 8'd1;
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed steps with a write-back scoreboard and a behavioural ALU on alu_c.
module tb_alu_op_sequencer;
    logic        clk = 0, rst = 1, instr_valid = 0, instr_ready;
    logic [11:0] instr = '0;
    logic [3:0]  alu_a, alu_b, alu_sel, alu_c, wb_data, rd_data;
    logic        wb_valid;
    logic [1:0]  wb_addr, rd_addr = '0;
    logic [7:0]  retired;
    int checks = 0, errors = 0, cyc = 0, wb_count = 0, ref_ret = 0, last_acc = 0, prev_acc = 0;
    logic [3:0] ref_rf [4];
    logic [5:0] sbq [$];

    alu_op_sequencer dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c(alu_c),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .retired(retired)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [3:0] alu_f(input logic [3:0] s, a, b);
        case (s)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return {3'b0, a == b};
            4'd6: return {3'b0, a > b};
            4'd7: return a << b;
            4'd8: return a >> b;
            default: return 4'd0;
        endcase
    endfunction

    always_comb alu_c = alu_f(alu_sel, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            wb_count++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL wb_unexpected observed addr %0d data %0h expected no write-back", wb_addr, wb_data);
            end else begin
                logic [5:0] e;
                e = sbq.pop_front();
                checks++;
                assert ({wb_addr, wb_data} === e) else begin
                    errors++;
                    $error("FAIL wb observed %0h expected %0h", {wb_addr, wb_data}, e);
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [1:0] rd, rs1, rs2, input logic [3:0] imm,
                        input bit expect_wb, input bit hold);
        int n = 0;
        logic [3:0] res;
        instr = op == 4'hf ? {op, rd, 2'b00, imm} : {op, rd, rs1, rs2, 2'b00};
        instr_valid = 1;
        while (!instr_ready && n < 30) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 30) chk("accept_timeout", n, 0);
        res = op == 4'hf ? imm : alu_f(op, ref_rf[rs1], ref_rf[rs2]);
        if (expect_wb) begin
            sbq.push_back({rd, res});
            ref_rf[rd] = res;
            ref_ret++;
        end
        @(posedge clk); #1;
        prev_acc = last_acc;
        last_acc = cyc;
        if (!hold) instr_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || !instr_ready) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk("drain_timeout", n, 0);
    endtask

    task automatic peek(input string tag, input logic [1:0] a, input logic [3:0] exp);
        rd_addr = a; #1;
        chk(tag, rd_data, exp);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) ref_rf[i] = 0;
        #2;
        chk("rst_ready", instr_ready, 0);
        chk("rst_alu", {alu_a, alu_b, alu_sel}, 0);
        chk("rst_wb", {wb_valid, wb_addr, wb_data}, 0);
        chk("rst_retired", retired, 0);
        chk("rst_rd_data", rd_data, 0);
        @(posedge clk); #1; rst = 0; #1;
        chk("ready_after_rst", instr_ready, 1);

        send(4'hf, 2'd1, 0, 0, 4'd5, 1, 0);
        send(4'hf, 2'd2, 0, 0, 4'd3, 1, 0);
        send(4'h0, 2'd3, 2'd1, 2'd2, 0, 1, 0);
        drain();
        peek("rd_r3_add", 2'd3, 4'd8);
        chk("retired_3", retired, 3);

        send(4'h1, 2'd0, 2'd2, 2'd1, 0, 1, 0);
        drain();
        peek("rd_r0_sub", 2'd0, 4'b1110);
        send(4'h7, 2'd0, 2'd1, 2'd2, 0, 1, 0);
        drain();
        peek("rd_r0_shl", 2'd0, 4'b1000);
        send(4'h6, 2'd0, 2'd1, 2'd2, 0, 1, 0);
        drain();
        peek("rd_r0_gt", 2'd0, 4'b0001);

        send(4'h4, 2'd0, 2'd1, 2'd2, 0, 1, 1);
        send(4'h2, 2'd3, 2'd0, 2'd1, 0, 1, 1);
        chk("b2b_gap1", last_acc - prev_acc, 3);
        send(4'h3, 2'd3, 2'd3, 2'd3, 0, 1, 1);
        chk("b2b_gap2", last_acc - prev_acc, 3);
        send(4'h8, 2'd0, 2'd1, 2'd0, 0, 1, 0);
        chk("b2b_gap3", last_acc - prev_acc, 3);
        drain();
        chk("retired_b2b", retired, 8'(ref_ret));
        peek("rd_r3_b2b", 2'd3, ref_rf[3]);

        send(4'ha, 2'd3, 2'd1, 2'd2, 0, 1, 0);
        drain();
        peek("rd_r3_reserved", 2'd3, 4'd0);
        chk("retired_reserved", retired, 8'(ref_ret));

        send(4'hf, 2'd3, 0, 0, 4'd9, 1, 0);
        drain();
        send(4'h0, 2'd3, 2'd1, 2'd2, 0, 0, 0);
        rst = 1; #1;
        chk("mid_rst_ready", instr_ready, 0);
        chk("mid_rst_outs", {alu_a, alu_b, alu_sel, wb_valid, wb_addr, wb_data, retired}, 0);
        peek("mid_rst_r3", 2'd3, 4'd0);
        repeat (2) @(posedge clk);
        #1; rst = 0; #1;
        for (int i = 0; i < 4; i++) ref_rf[i] = 0;
        ref_ret = 0;
        chk("ready_after_mid_rst", instr_ready, 1);
        repeat (4) @(posedge clk);
        #1;
        peek("r3_after_mid_rst", 2'd3, 4'd0);
        chk("retired_after_mid_rst", retired, 0);

        wb_count = 0;
        for (int i = 0; i < 256; i++)
            send(4'hf, 2'(i), 0, 0, 4'(i * 7), 1, 0);
        drain();
        chk("wb_count_256", wb_count, 256);
        chk("retired_wrap", retired, 0);
        peek("rd_r2_last", 2'd2, 4'((254 * 7) % 16));

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
